// File: rtl/spm_port_arbiter_pkg.sv
// spm_port_arbiter_pkg: pipeline-wide func3 codes, arbiter FSM encoding and access width helper
package spm_port_arbiter_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SRV_I = 2'd1;
    localparam logic [1:0] SRV_D = 2'd2;
    function automatic logic [2:0] access_width(input logic [2:0] func3);
        return func3[1:0] == 2'b00 ? 3'd1 : func3[1:0] == 2'b01 ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/spm_port_arbiter_if.sv
// spm_port_arbiter_if: fetch, data and memory-side signals of the shared scratchpad port
interface spm_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_func3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_isel;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_func3;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_isel, mem_addr, mem_read, mem_write, mem_func3, mem_wdata
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
               mem_isel, mem_addr, mem_read, mem_write, mem_func3, mem_wdata
    );
endinterface

// File: rtl/spm_access_check.sv
// spm_access_check: decides whether a data request has a usable func3, alignment and range
module spm_access_check import spm_port_arbiter_pkg::*; #(
    parameter int MEM_BYTES = 1024
) (
    input  logic [2:0]  func3,
    input  logic        we,
    input  logic [31:0] addr,
    output logic        legal
);
    logic        f3_ok;
    logic        aligned;
    logic [32:0] end_addr;
    // stores only take signed widths; range end is 33-bit so a high offset cannot wrap into range
    always_comb begin
        f3_ok    = func3 == F3_B || func3 == F3_H || func3 == F3_W || (!we && (func3 == F3_BU || func3 == F3_HU));
        aligned  = func3[1:0] == 2'b00 || (func3[1:0] == 2'b01 ? !addr[0] : addr[1:0] == 2'b00);
        end_addr = {1'b0, addr} + {30'd0, access_width(func3)};
        legal    = f3_ok && aligned && end_addr <= 33'(MEM_BYTES / 2);
    end
endmodule

// File: rtl/spm_port_arbiter.sv
// spm_port_arbiter: schedules fetch and data accesses onto the single-ported unified memory
module spm_port_arbiter import spm_port_arbiter_pkg::*; #(
    parameter int MEM_BYTES    = 1024,
    parameter int MAX_D_STREAK = 3
) (
    input  logic clk,
    input  logic rst,
    spm_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    logic          legal;
    logic          d_take;
    logic          d_access;
    logic          d_load;
    logic          d_bad;
    logic [1:0]    state;
    logic [SW-1:0] streak;

    spm_access_check #(.MEM_BYTES(MEM_BYTES)) u_check (
        .func3 (bus.d_func3),
        .we    (bus.d_we),
        .addr  (bus.d_addr),
        .legal (legal)
    );

    // data wins the slot unless a waiting fetch has already been passed over MAX_D_STREAK times
    always_comb begin
        d_take        = !rst && bus.d_req && (!bus.if_req || streak < SW'(MAX_D_STREAK));
        d_access      = d_take && legal;
        bus.d_gnt     = d_take;
        bus.if_gnt    = !rst && bus.if_req && !d_take;
        bus.mem_isel  = !d_access;
        bus.mem_addr  = d_access ? bus.d_addr : bus.if_addr;
        bus.mem_read  = d_access && !bus.d_we;
        bus.mem_write = d_access && bus.d_we;
        bus.mem_func3 = bus.d_func3;
        bus.mem_wdata = bus.d_wdata;
        bus.if_rvalid = !rst && state == SRV_I;
        bus.d_rvalid  = !rst && state == SRV_D && d_load;
        bus.d_err     = !rst && state == SRV_D && d_bad;
    end

    // state follows the grant; read data is captured at the end of the grant cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            streak      <= '0;
            d_load      <= 1'b0;
            d_bad       <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
        end else begin
            state  <= d_take ? SRV_D : bus.if_gnt ? SRV_I : IDLE;
            streak <= (!bus.if_req || bus.if_gnt) ? '0 :
                      (d_take && streak < SW'(MAX_D_STREAK)) ? streak + 1'b1 : streak;
            d_load <= d_access && !bus.d_we;
            d_bad  <= d_take && !legal;
            if (bus.if_gnt) bus.if_rdata <= bus.mem_rdata;
            if (d_access && !bus.d_we) bus.d_rdata <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_spm_port_arbiter.sv
// tb_spm_port_arbiter: scoreboard bench with a memory model, directed cases and random traffic
module tb_spm_port_arbiter;
    import spm_port_arbiter_pkg::*;
    localparam int MEM_BYTES = 1024;
    localparam int MAX_D     = 3;
    localparam int DBASE     = MEM_BYTES / 2;

    typedef struct {logic [2:0] kind; logic [31:0] data;} resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int waitc = 0;
    logic [7:0] mem [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    resp_t exp_q[$];
    logic [9:0] mbase;
    logic [31:0] mraw;
    logic isel;
    string seq;

    always #5 clk = ~clk;

    spm_port_arbiter_if bus();

    spm_port_arbiter #(.MEM_BYTES(MEM_BYTES), .MAX_D_STREAK(MAX_D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[(a + 3) % MEM_BYTES], ref_mem[(a + 2) % MEM_BYTES],
                ref_mem[(a + 1) % MEM_BYTES], ref_mem[a % MEM_BYTES]};
    endfunction

    function automatic bit legal_ref(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int w;
        w = 1 << f3[1:0];
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        if (we && f3 > 3'd2) return 1'b0;
        if (a % 32'(w) != 0) return 1'b0;
        return (64'(a) + 64'(w)) <= 64'(DBASE);
    endfunction

    // memory model: combinational read, store commits at the clock edge
    always_comb begin
        mbase = bus.mem_isel ? bus.mem_addr[9:0] : 10'(DBASE) + {1'b0, bus.mem_addr[8:0]};
        mraw  = {mem[mbase + 10'd3], mem[mbase + 10'd2], mem[mbase + 10'd1], mem[mbase]};
        bus.mem_rdata = bus.mem_isel ? mraw : extend(mraw, bus.mem_func3);
    end

    always @(posedge clk) begin
        if (bus.mem_write)
            for (int k = 0; k < (1 << bus.mem_func3[1:0]); k++)
                mem[10'(int'(mbase) + k)] <= bus.mem_wdata[8*k +: 8];
    end

    // reference model: predicts grants and memory controls, queues expected responses
    always @(negedge clk) begin
        bit ed, ei, lg;
        int a;
        if (rst) begin
            check("rst_bus", {bus.if_gnt, bus.d_gnt, bus.mem_read, bus.mem_write, bus.mem_isel}, 32'b00001);
            waitc = 0;
        end else begin
            lg = legal_ref(bus.d_we, bus.d_func3, bus.d_addr);
            ed = bus.d_req && (!bus.if_req || waitc < MAX_D);
            ei = bus.if_req && !ed;
            check("grant", {bus.if_gnt, bus.d_gnt}, {ei, ed});
            check("mem_ctl", {bus.mem_isel, bus.mem_read, bus.mem_write},
                  {!(ed && lg), ed && lg && !bus.d_we, ed && lg && bus.d_we});
            if (ei) begin
                check("fetch_addr", bus.mem_addr, bus.if_addr);
                exp_q.push_back('{kind: 3'b100, data: ref_word(int'(bus.if_addr % MEM_BYTES))});
            end
            if (ed && !lg) exp_q.push_back('{kind: 3'b001, data: 32'd0});
            if (ed && lg) begin
                a = DBASE + int'(bus.d_addr);
                check("data_addr", bus.mem_addr, bus.d_addr);
                if (bus.d_we) begin
                    check("store_bus", {bus.mem_func3, bus.mem_wdata[28:0]}, {bus.d_func3, bus.d_wdata[28:0]});
                    for (int k = 0; k < (1 << bus.d_func3[1:0]); k++)
                        ref_mem[a + k] = bus.d_wdata[8*k +: 8];
                end else begin
                    exp_q.push_back('{kind: 3'b010, data: extend(ref_word(a), bus.d_func3)});
                end
            end
            waitc = (ei || !bus.if_req) ? 0 : waitc + 1;
        end
    end

    // monitor: one expected response (or none) per cycle, compared against what the DUT presents
    always @(posedge clk) begin
        resp_t e;
        logic [2:0] act;
        #2;
        act = {bus.if_rvalid, bus.d_rvalid, bus.d_err};
        if (rst) begin
            exp_q.delete();
            check("rst_resp", act, 0);
        end else begin
            e.kind = 3'b000;
            e.data = 32'd0;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check("resp_kind", act, e.kind);
            if (e.kind == 3'b100) check("if_rdata", bus.if_rdata, e.data);
            if (e.kind == 3'b010) check("d_rdata", bus.d_rdata, e.data);
        end
    end

    task automatic data_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic gisel);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        gisel = 1'b1;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_func3 = f3; bus.d_addr = a; bus.d_wdata = wd;
        while (!done && n < 20) begin
            @(negedge clk);
            done = bus.d_gnt;
            gisel = bus.mem_isel;
            @(posedge clk);
            #1;
            n++;
        end
        bus.d_req = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL data_op_timeout: no d_gnt after %0d cycles, required within 20", n);
        end
    endtask

    task automatic random_phase(input int cycles);
        bit gi, gd;
        logic [2:0] picks [5];
        logic [31:0] a;
        picks = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            gi = bus.if_gnt;
            gd = bus.d_gnt;
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                bus.if_req = 1'b0;
                bus.d_req = 1'b0;
                continue;
            end
            if (gi) bus.if_req = 1'b0;
            if (gd) bus.d_req = 1'b0;
            if (!bus.if_req && $urandom_range(0, 2) != 0) begin
                bus.if_req = 1'b1;
                bus.if_addr = 32'(4 * $urandom_range(0, MEM_BYTES / 4 - 1));
            end
            if (!bus.d_req && $urandom_range(0, 2) != 0) begin
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(DBASE - 12, DBASE + 8)) : 32'($urandom_range(0, DBASE - 1));
                if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
                bus.d_req = 1'b1;
                bus.d_we = 1'($urandom_range(0, 1));
                bus.d_func3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : picks[$urandom_range(0, 4)];
                bus.d_addr = a;
                bus.d_wdata = $urandom;
            end
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        int diffs;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_func3 = '0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            r = 8'($urandom);
            if (i >= 8 && i < 12) r = 8'(8'h11 * (i - 7));
            if (i >= DBASE + 4 && i < DBASE + 8) r = (i == DBASE + 4) ? 8'd9 : 8'd0;
            mem[i] <= r;
            ref_mem[i] = r;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_valids", {bus.if_rvalid, bus.d_rvalid, bus.d_err}, 0);
        check("reset_if_rdata", bus.if_rdata, 0);
        check("reset_d_rdata", bus.d_rdata, 0);

        bus.if_req = 1'b1;
        bus.if_addr = 32'h8;
        repeat (3) begin
            @(negedge clk);
            check("fetch_only_gnt", bus.if_gnt, 1);
            @(posedge clk);
            #1;
        end
        bus.if_req = 1'b0;
        check("fetch_only_data", bus.if_rdata, 32'h44332211);
        @(posedge clk);
        #1;

        data_op(1'b0, F3_W, 32'h4, 32'h0, isel);
        check("lw_isel", isel, 0);
        check("lw_rvalid", bus.d_rvalid, 1);
        check("lw_rdata", bus.d_rdata, 32'd9);

        seq = "";
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_func3 = F3_W; bus.d_addr = 32'h8;
        repeat (6) begin
            @(negedge clk);
            seq = {seq, bus.d_gnt ? "D" : bus.if_gnt ? "I" : "-"};
            @(posedge clk);
            #1;
        end
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
        vectors++;
        if (seq != "DDDIDD") begin
            miscompares++;
            $display("FAIL contention_seq: got %s expected DDDIDD", seq);
        end
        @(posedge clk);
        #1;

        data_op(1'b1, F3_B, 32'h10, 32'h123456AB, isel);
        check("sb_no_rvalid", {bus.d_rvalid, bus.d_err}, 0);
        data_op(1'b0, F3_BU, 32'h10, 32'h0, isel);
        check("lbu_rdata", bus.d_rdata, 32'h000000AB);

        data_op(1'b0, F3_W, 32'h2, 32'h0, isel);
        check("misaligned_err", {bus.d_err, bus.d_rvalid}, 2'b10);
        check("misaligned_hold", bus.d_rdata, 32'hAB);
        data_op(1'b0, F3_W, 32'h1FE, 32'h0, isel);
        check("oor_1fe_err", {bus.d_err, bus.d_rvalid}, 2'b10);
        data_op(1'b0, F3_W, 32'h200, 32'h0, isel);
        check("oor_200_err", {bus.d_err, bus.d_rvalid}, 2'b10);
        data_op(1'b1, F3_BU, 32'h10, 32'h55, isel);
        check("bad_f3_err", {bus.d_err, bus.d_rvalid}, 2'b10);
        check("bad_f3_isel", isel, 1);
        data_op(1'b0, F3_BU, 32'h10, 32'h0, isel);
        check("mem_untouched", bus.d_rdata, 32'h000000AB);

        data_op(1'b0, F3_W, 32'h4, 32'h0, isel);
        rst = 1'b1;
        #1;
        check("rst_mid_rvalid", bus.d_rvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_rdata", bus.d_rdata, 0);
        check("rst_mid_state", 32'(dut.state), 32'(IDLE));
        check("rst_mid_streak", 32'(dut.streak), 0);

        random_phase(3000);
        repeat (3) @(posedge clk);
        #1;
        diffs = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("mem_image", 32'(diffs), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
